// File: rtl/core_pkg.sv
// Shared types for the fetch predictor: 2-bit branch counter and BTB entry layout.
package core_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  // Entry fields are sized for the widest supported word; narrower words zero-extend.
  localparam int MaxWord = 64;

  typedef struct packed {
    logic               valid;
    logic [MaxWord-1:0] tag;
    logic [MaxWord-1:0] target;
    ctr_t               ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    if (taken) begin
      res = (ctr == ST) ? ST : ctr + 2'd1;
    end else begin
      res = (ctr == SNT) ? SNT : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/Btb_Table.sv
// Direct-mapped branch target buffer: combinational lookup port plus one
// registered update port for resolved conditional branches.
module Btb_Table
  import core_pkg::*;
#(
  parameter int WordSize = 32,
  parameter int Entries  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WordSize-1:0] lkp_pc_i,
  output logic                lkp_hit_o,
  output logic [1:0]          lkp_ctr_o,
  output logic [WordSize-1:0] lkp_target_o,
  input  logic                upd_valid_i,
  input  logic [WordSize-1:0] upd_pc_i,
  input  logic [WordSize-1:0] upd_target_i,
  input  logic                upd_taken_i
);

  localparam int IdxW = $clog2(Entries);
  localparam int TagW = WordSize - IdxW - 2;

  btb_entry_t btb_q [Entries];

  logic [IdxW-1:0] lkp_idx_s;
  logic [IdxW-1:0] upd_idx_s;
  logic [TagW-1:0] lkp_tag_s;
  logic [TagW-1:0] upd_tag_s;
  btb_entry_t      upd_entry_s;
  btb_entry_t      upd_entry_d;
  logic            upd_hit_s;
  logic            upd_we_s;
  logic            unused_ok_s;

  assign lkp_idx_s   = lkp_pc_i[IdxW+1:2];
  assign lkp_tag_s   = lkp_pc_i[WordSize-1:IdxW+2];
  assign upd_idx_s   = upd_pc_i[IdxW+1:2];
  assign upd_tag_s   = upd_pc_i[WordSize-1:IdxW+2];
  assign unused_ok_s = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

  assign lkp_hit_o    = btb_q[lkp_idx_s].valid && (btb_q[lkp_idx_s].tag == MaxWord'(lkp_tag_s));
  assign lkp_ctr_o    = btb_q[lkp_idx_s].ctr;
  assign lkp_target_o = btb_q[lkp_idx_s].target[WordSize-1:0];

  assign upd_entry_s = btb_q[upd_idx_s];
  assign upd_hit_s   = upd_entry_s.valid && (upd_entry_s.tag == MaxWord'(upd_tag_s));

  // A taken miss allocates (evicting any alias); a not-taken miss leaves the table alone.
  always_comb begin
    upd_we_s    = 1'b0;
    upd_entry_d = upd_entry_s;
    if (upd_valid_i) begin
      if (upd_hit_s) begin
        upd_we_s        = 1'b1;
        upd_entry_d.ctr = ctr_update(upd_entry_s.ctr, upd_taken_i);
        if (upd_taken_i) begin
          upd_entry_d.target = MaxWord'(upd_target_i);
        end else begin
          upd_entry_d.target = upd_entry_s.target;
        end
      end else if (upd_taken_i) begin
        upd_we_s    = 1'b1;
        upd_entry_d = '{valid: 1'b1, tag: MaxWord'(upd_tag_s),
                        target: MaxWord'(upd_target_i), ctr: WT};
      end else begin
        upd_we_s = 1'b0;
      end
    end else begin
      upd_we_s = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Entries; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (upd_we_s) begin
      btb_q[upd_idx_s] <= upd_entry_d;
    end
  end

endmodule

// File: rtl/fetch_predictor.sv
// Fetch PC register with BTB-driven next-PC selection; redirects from the
// branch controller override stalls, and BTB training runs every cycle.
module fetch_predictor
  import core_pkg::*;
#(
  parameter int                  WordSize    = 32,
  parameter int                  Entries     = 8,
  parameter logic [WordSize-1:0] ResetVector = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [WordSize-1:0] flush_pc,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic [WordSize-1:0] upd_target,
  input  logic                upd_taken,
  output logic [WordSize-1:0] pc,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_pc,
  output logic [WordSize-1:0] pred_adder
);

  logic [WordSize-1:0] pc_q;
  logic [WordSize-1:0] pc_d;
  logic                hit_s;
  logic [1:0]          ctr_s;
  logic [WordSize-1:0] target_s;

  Btb_Table #(
    .WordSize (WordSize),
    .Entries  (Entries)
  ) u_btb (
    .clk_i        (clk),
    .rst_i        (rst),
    .lkp_pc_i     (pc_q),
    .lkp_hit_o    (hit_s),
    .lkp_ctr_o    (ctr_s),
    .lkp_target_o (target_s),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_target_i (upd_target),
    .upd_taken_i  (upd_taken)
  );

  assign pc         = pc_q;
  assign pred_adder = pc_q + WordSize'(4);
  assign pred_taken = hit_s & ctr_s[1];
  assign pred_pc    = pred_taken ? target_s : pred_adder;

  // Next fetch address: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = pred_pc;
    if (flush) begin
      pc_d = flush_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= ResetVector;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed bench for fetch_predictor (WordSize=32, Entries=8, ResetVector=0).
module tb_fetch_predictor;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic [31:0] pred_adder;

  int total_cnt = 0;
  int bad_cnt   = 0;

  fetch_predictor #(
    .WordSize    (32),
    .Entries     (8),
    .ResetVector (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .pc         (pc),
    .pred_taken (pred_taken),
    .pred_pc    (pred_pc),
    .pred_adder (pred_adder)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One active edge, then settle on the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_upd(input logic v, input logic [31:0] a, input logic [31:0] t, input logic tk);
    upd_valid  = v;
    upd_pc     = a;
    upd_target = t;
    upd_taken  = tk;
  endtask

  // Counter walk at 0x10 starting from WT: outcome per update and expected prediction after it.
  logic       walk_taken [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       walk_pred  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    check_val("rst_pc", pc, 32'h0);
    check_val("rst_pred_taken", {31'h0, pred_taken}, 32'h0);
    check_val("rst_pred_pc", pred_pc, 32'h4);
    check_val("rst_pred_adder", pred_adder, 32'h4);
    tick();
    check_val("seq_pc4", pc, 32'h4);
    check_val("seq_pt4", {31'h0, pred_taken}, 32'h0);
    tick();
    check_val("seq_pc8", pc, 32'h8);
    check_val("seq_pt8", {31'h0, pred_taken}, 32'h0);

    set_upd(1'b1, 32'h10, 32'h40, 1'b1);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    check_val("seq_pcC", pc, 32'hC);
    check_val("seq_ptC", {31'h0, pred_taken}, 32'h0);
    tick();
    check_val("alloc_pc10", pc, 32'h10);
    check_val("alloc_pt", {31'h0, pred_taken}, 32'h1);
    check_val("alloc_ppc", pred_pc, 32'h40);
    tick();
    check_val("alloc_next_pc", pc, 32'h40);

    flush = 1'b1; flush_pc = 32'h10;
    tick();
    flush = 1'b0; stall = 1'b1;
    check_val("walk_start_pt", {31'h0, pred_taken}, 32'h1);
    set_upd(1'b1, 32'h10, 32'h50, 1'b0);
    check_val("same_cycle_pt", {31'h0, pred_taken}, 32'h1);
    for (int i = 0; i < 9; i++) begin
      set_upd(1'b1, 32'h10, 32'h50, walk_taken[i]);
      tick();
      check_val($sformatf("walk%0d_pt", i), {31'h0, pred_taken}, {31'h0, walk_pred[i]});
      check_val($sformatf("walk%0d_ppc", i), pred_pc, walk_pred[i] ? 32'h50 : 32'h14);
    end
    check_val("walk_stall_pc", pc, 32'h10);

    // Counter is WNT here; the update in the flush cycle must still land.
    flush = 1'b1; flush_pc = 32'h80;
    set_upd(1'b1, 32'h10, 32'h50, 1'b1);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    flush = 1'b0;
    check_val("flush_over_stall", pc, 32'h80);
    tick();
    check_val("stall_hold", pc, 32'h80);
    stall = 1'b0;

    flush = 1'b1; flush_pc = 32'h10;
    tick();
    check_val("flush_upd_pt", {31'h0, pred_taken}, 32'h1);
    check_val("flush_upd_ppc", pred_pc, 32'h50);
    set_upd(1'b1, 32'h30, 32'h60, 1'b1);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    check_val("alias_10_pt", {31'h0, pred_taken}, 32'h0);
    check_val("alias_10_ppc", pred_pc, 32'h14);
    flush_pc = 32'h30;
    tick();
    flush = 1'b0;
    check_val("alias_30_pt", {31'h0, pred_taken}, 32'h1);
    check_val("alias_30_ppc", pred_pc, 32'h60);
    stall = 1'b1;
    set_upd(1'b1, 32'h10, 32'h70, 1'b0);
    tick();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    check_val("nt_miss_pc", pc, 32'h30);
    check_val("nt_miss_pt", {31'h0, pred_taken}, 32'h1);
    check_val("nt_miss_ppc", pred_pc, 32'h60);

    stall = 1'b0; flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    check_val("wrap_pc", pc, 32'hFFFF_FFFC);
    check_val("wrap_adder", pred_adder, 32'h0);
    check_val("wrap_pt", {31'h0, pred_taken}, 32'h0);
    check_val("wrap_ppc", pred_pc, 32'h0);
    tick();
    check_val("wrap_next_pc", pc, 32'h0);

    rst = 1'b1;
    set_upd(1'b1, 32'h0, 32'h20, 1'b1);
    tick();
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0);
    check_val("mid_rst_pc", pc, 32'h0);
    check_val("mid_rst_pt", {31'h0, pred_taken}, 32'h0);
    check_val("mid_rst_ppc", pred_pc, 32'h4);
    flush = 1'b1; flush_pc = 32'h30;
    tick();
    check_val("mid_rst_30_pt", {31'h0, pred_taken}, 32'h0);
    flush_pc = 32'h10;
    tick();
    flush = 1'b0;
    check_val("mid_rst_10_pt", {31'h0, pred_taken}, 32'h0);
    check_val("mid_rst_10_ppc", pred_pc, 32'h14);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
